// File: rtl/sync_filter_pkg.sv
// sync_filter_pkg: shared constants and counter-width helper for the multi-channel input synchroniser
package sync_filter_pkg;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int KEY_FILTER_CYCLES = 50000;
  function automatic int cnt_width(input int filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction
endpackage

// File: rtl/sync_filter_multi_if.sv
// sync_filter_multi_if: raw inputs + glitch clear (master drives) and filtered level, rise/fall pulses, sticky glitch flags (slave drives)
interface sync_filter_multi_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] indata;
  logic clear_glitch;
  logic [WIDTH-1:0] outdata;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] glitch;
  modport master (output indata, clear_glitch, input outdata, rise, fall, glitch);
  modport slave (input indata, clear_glitch, output outdata, rise, fall, glitch);
endinterface

// File: rtl/sync_filter_bit.sv
// sync_filter_bit: one channel - din through a STAGES flop chain, debounce to dout, registered rise/fall pulses, sticky glitch
module sync_filter_bit
  import sync_filter_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int FILTER_CYCLES = 3,
  parameter bit RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic clear_glitch,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic glitch
);
  localparam int CW = cnt_width(FILTER_CYCLES);
  logic [STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic s, diff, done, rej;
  assign s = sync[STAGES-1];
  assign diff = s != dout;
  assign done = diff && cnt == CW'(FILTER_CYCLES - 1);
  assign rej = !diff && cnt != '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= {STAGES{RESET_BIT}};
      cnt <= '0;
      dout <= RESET_BIT;
      rise <= 1'b0;
      fall <= 1'b0;
      glitch <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      cnt <= (diff && !done) ? cnt + 1'b1 : '0;
      dout <= done ? s : dout;
      rise <= done && s;
      fall <= done && !s;
      glitch <= rej || (glitch && !clear_glitch);
    end
  end
endmodule

// File: rtl/sync_filter_multi.sv
// sync_filter_multi: WIDTH independent synchroniser/debounce channels; clk, reset (sync active-high), bus carries indata/clear_glitch in and outdata/rise/fall/glitch out
module sync_filter_multi
  import sync_filter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STAGES = 2,
  parameter int FILTER_CYCLES = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic clk,
  input logic reset,
  sync_filter_multi_if.slave bus
);
  logic [WIDTH-1:0] o, r, f, g;
  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX || FILTER_CYCLES < 1 || FILTER_CYCLES > 65535) begin : g_bad_param
    $error("sync_filter_multi: STAGES or FILTER_CYCLES out of range");
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_filter_bit #(
      .STAGES(STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_BIT(RESET_VAL[i])
    ) u_bit (
      .clk(clk),
      .reset(reset),
      .din(bus.indata[i]),
      .clear_glitch(bus.clear_glitch),
      .dout(o[i]),
      .rise(r[i]),
      .fall(f[i]),
      .glitch(g[i])
    );
  end
  assign bus.outdata = o;
  assign bus.rise = r;
  assign bus.fall = f;
  assign bus.glitch = g;
endmodule

// File: tb/tb_sync_filter_multi.sv
// tb_sync_filter_multi: scoreboard bench for three sync_filter_multi configurations driven by identical stimulus
module tb_sync_filter_multi;
  typedef struct packed {
    logic [3:0] o;
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] g;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  bit done_stim = 1'b0;
  int st[3] = '{2, 2, 3};
  int fc[3] = '{3, 3, 1};
  logic [3:0] rv[3] = '{4'b0000, 4'b1010, 4'b0000};
  logic [3:0] ch[3][4];
  logic [3:0] hs[3][4];
  int nh[3];
  logic [3:0] lvl[3];
  logic [3:0] glt[3];
  exp_t q0[$], q1[$], q2[$];
  sync_filter_multi_if #(.WIDTH(4)) b0 ();
  sync_filter_multi_if #(.WIDTH(4)) b1 ();
  sync_filter_multi_if #(.WIDTH(4)) b2 ();
  sync_filter_multi #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(3), .RESET_VAL(4'b0000)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  sync_filter_multi #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(3), .RESET_VAL(4'b1010)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  sync_filter_multi #(.WIDTH(4), .STAGES(3), .FILTER_CYCLES(1), .RESET_VAL(4'b0000)) dut2 (.clk(clk), .reset(reset), .bus(b2));
  always #5 clk = ~clk;
  // Reference: the level of a channel flips once the last FILTER_CYCLES synchronised samples all
  // disagree with it; a glitch is a sample that agrees with the level right after one that did not.
  task automatic model(input int k, input bit r, input logic [3:0] d, input bit c);
    logic [3:0] s, tg, gs;
    bit all;
    exp_t e;
    if (r) begin
      for (int j = 0; j < 4; j++) ch[k][j] = rv[k];
      lvl[k] = rv[k];
      glt[k] = 4'b0;
      nh[k] = 0;
      e = '{o: rv[k], r: 4'b0, f: 4'b0, g: 4'b0};
    end else begin
      s = ch[k][st[k]-1];
      for (int j = 3; j > 0; j--) hs[k][j] = hs[k][j-1];
      hs[k][0] = s;
      if (nh[k] < 4) nh[k]++;
      tg = 4'b0;
      gs = 4'b0;
      for (int i = 0; i < 4; i++) begin
        all = nh[k] >= fc[k];
        for (int j = 0; j < fc[k]; j++)
          if (j < nh[k] && hs[k][j][i] == lvl[k][i]) all = 1'b0;
        tg[i] = all;
        gs[i] = s[i] == lvl[k][i] && nh[k] > 1 && hs[k][1][i] != lvl[k][i];
      end
      glt[k] = gs | (glt[k] & ~{4{c}});
      e.r = tg & s;
      e.f = tg & ~s;
      lvl[k] = lvl[k] ^ tg;
      e.o = lvl[k];
      e.g = glt[k];
      for (int j = 3; j > 0; j--) ch[k][j] = ch[k][j-1];
      ch[k][0] = d;
    end
    if (k == 0) q0.push_back(e);
    else if (k == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask
  task automatic step(input bit r, input logic [3:0] d, input bit c);
    @(negedge clk);
    reset = r;
    b0.indata = d; b1.indata = d; b2.indata = d;
    b0.clear_glitch = c; b1.clear_glitch = c; b2.clear_glitch = c;
    for (int k = 0; k < 3; k++) model(k, r, d, c);
  endtask
  task automatic hold(input int n, input logic [3:0] d);
    for (int j = 0; j < n; j++) step(1'b0, d, 1'b0);
  endtask
  task automatic cmp(input string name, input exp_t a, input exp_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s at %0t: got out=%b rise=%b fall=%b glitch=%b, expected out=%b rise=%b fall=%b glitch=%b",
               name, $time, a.o, a.r, a.f, a.g, e.o, e.r, e.f, e.g);
    end
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin e = q0.pop_front(); cmp("dut0", {b0.outdata, b0.rise, b0.fall, b0.glitch}, e); end
      if (q1.size() > 0) begin e = q1.pop_front(); cmp("dut1_rv1010", {b1.outdata, b1.rise, b1.fall, b1.glitch}, e); end
      if (q2.size() > 0) begin e = q2.pop_front(); cmp("dut2_s3f1", {b2.outdata, b2.rise, b2.fall, b2.glitch}, e); end
    end
  end
  initial begin : stimulus
    logic [3:0] d;
    bit c, r;
    b0.indata = 4'b0; b1.indata = 4'b0; b2.indata = 4'b0;
    b0.clear_glitch = 1'b0; b1.clear_glitch = 1'b0; b2.clear_glitch = 1'b0;
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b1);
    hold(6, 4'b0000);
    hold(8, 4'b0001);
    hold(2, 4'b0011);
    hold(8, 4'b0001);
    step(1'b0, 4'b0001, 1'b1);
    hold(3, 4'b0001);
    hold(10, 4'b1111);
    hold(8, 4'b0000);
    hold(2, 4'b0100);
    step(1'b1, 4'b0100, 1'b0);
    hold(8, 4'b0100);
    hold(6, 4'b0000);
    hold(2, 4'b1000);
    for (int j = 0; j < 6; j++) step(1'b0, 4'b0000, 1'b1);
    hold(4, 4'b0000);
    d = 4'b0000;
    for (int j = 0; j < 800; j++) begin
      d = d ^ (4'($urandom) & 4'($urandom));
      c = $urandom_range(0, 15) == 0;
      r = $urandom_range(0, 149) == 0;
      step(r, d, c);
    end
    hold(10, d);
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q0.size() + q1.size() + q2.size());
    end
    done_stim = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
